// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ---- mux_arb_pkg: shared defaults and mode encoding for mux_arb_nto1 ----
// ---- rev 1.0 ----
package mux_arb_pkg;
   localparam int N_CH_DEF  = 4;
   localparam int WIDTH_DEF = 8;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---- rr_arbiter: combinational round-robin grant, search starts after last ----
// ---- rev 1.0 ----
module rr_arbiter #(
   parameter  int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] last_i,
   output logic [N_CH-1:0] grant_o,
   output logic [CH_W-1:0] idx_o
);
   localparam logic [CH_W:0] LAST_CH = (CH_W+1)'(N_CH - 1);
   localparam logic [CH_W:0] NUM_CH  = (CH_W+1)'(N_CH);

   logic [CH_W:0]     start;
   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;
   logic [CH_W-1:0]   off;
   logic              found;
   logic [CH_W:0]     sum;

   always_comb begin
      start = ({1'b0, last_i} >= LAST_CH) ? '0 : {1'b0, last_i} + 1'b1;
      dbl   = {req_i, req_i} >> start;
      rot   = dbl[N_CH-1:0];
      found = 1'b0;
      off   = '0;
      // Descending scan so the lowest rotated position (closest after last) wins.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = CH_W'(i);
         end
      end
      sum = start + {1'b0, off};
      if (sum >= NUM_CH) begin
         sum = sum - NUM_CH;
      end
      idx_o   = found ? sum[CH_W-1:0] : '0;
      grant_o = found ? (N_CH'(1) << idx_o) : '0;
   end
endmodule
`default_nettype wire

// File: rtl/mux_arb_nto1.sv
`default_nettype none
// ---- mux_arb_nto1: N-to-1 valid/ready mux, fixed or round-robin, registered output ----
// ---- rev 1.0 ----
module mux_arb_nto1
   import mux_arb_pkg::*;
#(
   parameter  int N_CH  = N_CH_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int CH_W  = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode,
   input  logic [CH_W-1:0]       sel,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch,
   input  logic                  out_ready
);
   logic [N_CH-1:0]  rr_grant;
   logic [CH_W-1:0]  rr_idx;
   logic [N_CH-1:0]  fx_grant;
   logic [N_CH-1:0]  grant;
   logic [CH_W-1:0]  grant_idx;
   logic [WIDTH-1:0] sel_data;
   logic             load_en;
   logic             xfer;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [CH_W-1:0]  ch_q,    ch_d;
   logic [CH_W-1:0]  last_q,  last_d;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req_i   (in_valid),
      .last_i  (last_q),
      .grant_o (rr_grant),
      .idx_o   (rr_idx)
   );

   // Out-of-range sel matches no channel, so it yields no grant.
   always_comb begin
      fx_grant = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (CH_W'(i) == sel) begin
            fx_grant[i] = in_valid[i];
         end
      end
   end

   assign load_en   = !valid_q || out_ready;
   assign grant     = (mode == MODE_RR) ? rr_grant : fx_grant;
   assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
   assign in_ready  = reset ? '0 : (grant & {N_CH{load_en}});
   assign xfer      = |in_ready;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ch_d    = ch_q;
      last_d  = last_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = sel_data;
         ch_d    = grant_idx;
         last_d  = grant_idx;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         last_q  <= CH_W'(N_CH - 1);
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ch    = ch_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
`default_nettype none
// ---- tb_mux_arb_nto1: randomized and directed checks against a behavioural model ----
// ---- rev 1.0 ----
module tb_mux_arb_nto1;
   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;

   logic        mode_b;
   logic [1:0]  sel_b;
   logic [2:0]  in_valid_b;
   logic [23:0] in_data_b;
   logic [2:0]  in_ready_b;
   logic        out_valid_b;
   logic [7:0]  out_data_b;
   logic [1:0]  out_ch_b;
   logic        out_ready_b;

   int n_checks = 0;
   int n_errors = 0;

   bit       m_ov;
   logic [7:0] m_data;
   int       m_ch;
   int       m_last;

   mux_arb_nto1 #(.N_CH(4), .WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   mux_arb_nto1 #(.N_CH(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .reset(reset), .mode(mode_b), .sel(sel_b),
      .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_ch(out_ch_b),
      .out_ready(out_ready_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Channel the arbiter should pick this cycle, or -1 for none.
   function automatic int pick();
      if (mode == 1'b0) begin
         return in_valid[sel] ? int'(sel) : -1;
      end
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic step(input string tag);
      int g;
      logic [3:0] er;
      #1;
      g  = pick();
      er = '0;
      if (g >= 0 && (!m_ov || out_ready)) er[g] = 1'b1;
      check({tag, "_rdy"}, in_ready, er);
      @(posedge clk);
      if (er != 0) begin
         m_ov   = 1'b1;
         m_data = in_data[g*8 +: 8];
         m_ch   = g;
         m_last = g;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      check({tag, "_ov"},   out_valid, m_ov);
      check({tag, "_data"}, out_data,  m_data);
      check({tag, "_ch"},   out_ch,    m_ch);
   endtask

   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      #1;
      check("rst_async_ov", out_valid, 0);
      check("rst_rdy", in_ready, 0);
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_ov",   out_valid, 0);
      check("rst_data", out_data,  0);
      check("rst_ch",   out_ch,    0);
      check("rst_rdy2", in_ready,  0);
      reset  = 1'b0;
      m_ov   = 1'b0;
      m_data = '0;
      m_ch   = 0;
      m_last = 3;
   endtask

   initial begin
      logic [7:0] held;
      int         held_ch;
      reset = 1'b1;
      mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
      mode_b = 1'b0; sel_b = 2'd0; in_valid_b = '0; in_data_b = '0; out_ready_b = 1'b1;
      #6;
      apply_reset(3);

      // Round-robin over all channels right after reset.
      for (int i = 0; i < 8; i++) begin
         step("fair");
         check("fair_seq", out_ch, i % 4);
      end

      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step("sparse");
         check("sparse_seq", out_ch, (i % 2 == 0) ? 1 : 3);
      end

      mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'hA3A2A1A0;
      for (int i = 0; i < 4; i++) begin
         step("fixed");
         check("fixed_data", out_data, 8'hA2);
      end

      mode = 1'b1; out_ready = 1'b1; in_data = 32'h44332211;
      step("bp_load");
      held    = out_data;
      held_ch = int'(out_ch);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("bp_stall");
         check("bp_hold", out_data, held);
      end
      out_ready = 1'b1;
      step("bp_drain");
      check("bp_next", out_ch, (held_ch + 1) % 4);

      for (int i = 0; i < 300; i++) begin
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0; in_data = 32'h5C5B5A59;
      step("mr_pre");
      check("mr_pre_valid", out_valid, 1);
      apply_reset(1);
      out_ready = 1'b1;
      step("mr_post");
      check("mr_first_ch0", out_ch, 0);

      // Three-channel instance: out-of-range sel must never grant.
      in_valid = 4'h0;
      mode_b = 1'b0; sel_b = 2'd1; in_valid_b = 3'b111; in_data_b = 24'hC2C1C0; out_ready_b = 1'b0;
      #1;
      check("n3_rdy_sel1", in_ready_b, 3'b010);
      @(posedge clk); #1;
      check("n3_ov",   out_valid_b, 1);
      check("n3_ch",   out_ch_b,    1);
      check("n3_data", out_data_b,  8'hC1);
      sel_b = 2'd3; out_ready_b = 1'b1;
      #1;
      check("n3_oor_rdy", in_ready_b, 0);
      @(posedge clk); #1;
      check("n3_drain_ov", out_valid_b, 0);
      check("n3_oor_rdy2", in_ready_b, 0);
      check("n3_hold_data", out_data_b, 8'hC1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
